// File: rtl/cmac_tx_stream_mux.sv
// cmac_tx_stream_mux: packet-granular arbiter merging NUM_SRC AXI-Stream sources onto CMAC tx_axis.
// Packets longer than MAX_BEATS are cut (tlast+tuser on the cut beat) and their tail is discarded.
//
// state | meaning
// IDLE  | no packet owned; pick a source when tx_enable is high
// PASS  | forwarding beats of the granted source into the skid buffer
// DROP  | swallowing the tail of a truncated packet up to its tlast
module cmac_tx_stream_mux #(
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 512,
  parameter int ARB_MODE  = 1,
  parameter int MAX_BEATS = 256,
  localparam int KEEP_W   = DATA_W / 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      tx_enable,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [KEEP_W-1:0]         m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  input  logic                      m_axis_tready,
  output logic                      busy,
  output logic [NUM_SRC*32-1:0]     pkt_cnt,
  output logic [15:0]               trunc_cnt
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_nxt;
  logic [IDX_W-1:0] arb_idx, next_ptr;
  logic             arb_found;
  logic [15:0]      beat_cnt, beat_nxt;

  logic              sel_valid, sel_last, sel_ready, acc;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;

  logic push, push_last, push_user;
  logic pkt_inc, trunc_inc;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [KEEP_W-1:0] skid_keep;
  logic              skid_last, skid_user;

  logic pop, main_free;
  logic main_valid_nxt, skid_valid_nxt;
  logic main_from_skid, main_take_push, skid_load;
  logic [NUM_SRC-1:0] tready_nxt;

  assign busy = (state != ST_IDLE);

  assign sel_valid = s_axis_tvalid[grant];
  assign sel_last  = s_axis_tlast[grant];
  assign sel_ready = s_axis_tready[grant];
  assign sel_data  = s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
  assign sel_keep  = s_axis_tkeep[int'(grant)*KEEP_W +: KEEP_W];
  assign acc       = sel_valid & sel_ready & (state != ST_IDLE);

  assign next_ptr = (grant == IDX_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;

  // Scan starts at 0 for fixed priority, at rr_ptr for round-robin.
  always_comb begin
    int cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (ARB_MODE == 0) ? k : (int'(rr_ptr) + k) % NUM_SRC;
      if (!arb_found && s_axis_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    beat_nxt  = beat_cnt;
    rr_nxt    = rr_ptr;
    push      = 1'b0;
    push_last = sel_last;
    push_user = 1'b0;
    pkt_inc   = 1'b0;
    trunc_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_enable && arb_found) begin
          state_nxt = ST_PASS;
          grant_nxt = arb_idx;
          beat_nxt  = '0;
        end
      end
      ST_PASS: begin
        if (acc) begin
          push     = 1'b1;
          beat_nxt = beat_cnt + 16'd1;
          if (sel_last) begin
            state_nxt = ST_IDLE;
            pkt_inc   = 1'b1;
            rr_nxt    = next_ptr;
          end else if (beat_cnt == 16'(MAX_BEATS - 1)) begin
            push_last = 1'b1;
            push_user = 1'b1;
            pkt_inc   = 1'b1;
            trunc_inc = 1'b1;
            state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (acc && sel_last) begin
          state_nxt = ST_IDLE;
          rr_nxt    = next_ptr;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Two-entry skid: output register plus one spare; skid only fills while output is stalled.
  always_comb begin
    pop       = m_axis_tvalid & m_axis_tready;
    main_free = ~m_axis_tvalid | pop;
    if (main_free) begin
      main_valid_nxt = skid_valid | push;
      skid_valid_nxt = skid_valid & push;
      main_from_skid = skid_valid;
      main_take_push = push & ~skid_valid;
      skid_load      = skid_valid & push;
    end else begin
      main_valid_nxt = 1'b1;
      skid_valid_nxt = skid_valid | push;
      main_from_skid = 1'b0;
      main_take_push = 1'b0;
      skid_load      = push;
    end
  end

  // Ready is registered from next-cycle occupancy so m_axis_tready never reaches s_axis_tready.
  always_comb begin
    tready_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      tready_nxt[i] = (grant_nxt == IDX_W'(i)) &&
                      (((state_nxt == ST_PASS) && !(main_valid_nxt && skid_valid_nxt)) ||
                       (state_nxt == ST_DROP));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      grant         <= '0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      s_axis_tready <= '0;
      pkt_cnt       <= '0;
      trunc_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      rr_ptr        <= rr_nxt;
      beat_cnt      <= beat_nxt;
      s_axis_tready <= tready_nxt;
      if (pkt_inc) begin
        pkt_cnt[int'(grant)*32 +: 32] <= pkt_cnt[int'(grant)*32 +: 32] + 32'd1;
      end
      if (trunc_inc && (trunc_cnt != 16'hFFFF)) begin
        trunc_cnt <= trunc_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_keep     <= '0;
      skid_last     <= 1'b0;
      skid_user     <= 1'b0;
    end else begin
      m_axis_tvalid <= main_valid_nxt;
      skid_valid    <= skid_valid_nxt;
      if (main_from_skid) begin
        m_axis_tdata <= skid_data;
        m_axis_tkeep <= skid_keep;
        m_axis_tlast <= skid_last;
        m_axis_tuser <= skid_user;
      end else if (main_take_push) begin
        m_axis_tdata <= sel_data;
        m_axis_tkeep <= sel_keep;
        m_axis_tlast <= push_last;
        m_axis_tuser <= push_user;
      end
      if (skid_load) begin
        skid_data <= sel_data;
        skid_keep <= sel_keep;
        skid_last <= push_last;
        skid_user <= push_user;
      end
    end
  end

endmodule

// File: tb/tb_cmac_tx_stream_mux.sv
// Scoreboard bench for cmac_tx_stream_mux: dut0 is round-robin with MAX_BEATS=256,
// dut1 is fixed priority with MAX_BEATS=4 for the truncation cases.
module tb_cmac_tx_stream_mux;
  localparam int NUM_SRC = 2;
  localparam int DATA_W  = 512;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int ND      = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              user;
  } beat_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic                      aresetn   [ND];
  logic                      tx_enable [ND];
  logic [NUM_SRC*DATA_W-1:0] s_tdata   [ND];
  logic [NUM_SRC*KEEP_W-1:0] s_tkeep   [ND];
  logic [NUM_SRC-1:0]        s_tvalid  [ND];
  logic [NUM_SRC-1:0]        s_tlast   [ND];
  logic [NUM_SRC-1:0]        s_tready  [ND];
  logic [DATA_W-1:0]         m_tdata   [ND];
  logic [KEEP_W-1:0]         m_tkeep   [ND];
  logic                      m_tvalid  [ND];
  logic                      m_tlast   [ND];
  logic                      m_tuser   [ND];
  logic                      m_tready  [ND];
  logic                      busy      [ND];
  logic [NUM_SRC*32-1:0]     pkt_cnt   [ND];
  logic [15:0]               trunc_cnt [ND];

  beat_t exp_q [2][$];
  int total = 0;
  int bad   = 0;

  cmac_tx_stream_mux #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ARB_MODE(1), .MAX_BEATS(256)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn[0]), .tx_enable(tx_enable[0]),
    .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tlast(s_tlast[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]), .m_axis_tready(m_tready[0]),
    .busy(busy[0]), .pkt_cnt(pkt_cnt[0]), .trunc_cnt(trunc_cnt[0])
  );

  cmac_tx_stream_mux #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ARB_MODE(0), .MAX_BEATS(4)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn[1]), .tx_enable(tx_enable[1]),
    .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tlast(s_tlast[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]), .m_axis_tready(m_tready[1]),
    .busy(busy[1]), .pkt_cnt(pkt_cnt[1]), .trunc_cnt(trunc_cnt[1])
  );

  function automatic logic [DATA_W-1:0] mk_data(int src, int pkt, int beat);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int w = 0; w < DATA_W / 32; w++) v[w*32 +: 32] = {8'(src), 8'(pkt), 8'(beat), 8'(w)};
    return v;
  endfunction

  function automatic logic [KEEP_W-1:0] mk_keep(int pkt, int beat, int len);
    logic [KEEP_W-1:0] k;
    k = '1;
    if (beat == len - 1) k = k >> ((pkt * 7 + 3) % KEEP_W);
    return k;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Expected output of a packet of len beats through a mux that cuts at cut beats.
  task automatic exp_pkt(input int d, input int src, input int pkt, input int len, input int cut);
    int n;
    beat_t b;
    n = (len > cut) ? cut : len;
    for (int i = 0; i < n; i++) begin
      b.data = mk_data(src, pkt, i);
      b.keep = mk_keep(pkt, i, len);
      b.last = (i == n - 1);
      b.user = (len > cut) && (i == n - 1);
      exp_q[d].push_back(b);
    end
  endtask

  // Called right after a posedge (+#1); returns right after the posedge of the last handshake (+#1).
  task automatic send_pkt(input int d, input int src, input int pkt, input int len, input int nsend,
                          input bit hold, input int en_drop_at);
    int waited;
    for (int b = 0; b < nsend; b++) begin
      s_tdata[d][src*DATA_W +: DATA_W] = mk_data(src, pkt, b);
      s_tkeep[d][src*KEEP_W +: KEEP_W] = mk_keep(pkt, b, len);
      s_tlast[d][src]  = (b == len - 1);
      s_tvalid[d][src] = 1'b1;
      waited = 0;
      do begin
        @(negedge aclk);
        waited++;
      end while (!s_tready[d][src] && waited < 400);
      if (!s_tready[d][src]) begin
        total++;
        bad++;
        $display("FAIL drv%0d_src%0d_timeout: beat=%0d not accepted", d, src, b);
        s_tvalid[d][src] = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
      if (b == en_drop_at) tx_enable[d] = 1'b0;
    end
    if (!hold) begin
      s_tvalid[d][src] = 1'b0;
      s_tlast[d][src]  = 1'b0;
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 400) begin
      @(negedge aclk);
      n++;
    end
    repeat (3) @(negedge aclk);
    chk($sformatf("drain%0d_left", d), 64'(exp_q[d].size()), 64'd0);
  endtask

  initial begin
    bit done;
    int viol;

    for (int d = 0; d < ND; d++) begin
      aresetn[d]   = 1'b0;
      tx_enable[d] = 1'b1;
      s_tdata[d]   = '0;
      s_tkeep[d]   = '0;
      s_tvalid[d]  = '0;
      s_tlast[d]   = '0;
      m_tready[d]  = 1'b1;
    end

    fork
      forever begin
        beat_t got, want;
        @(negedge aclk);
        for (int d = 0; d < ND; d++) begin
          if (aresetn[d] && m_tvalid[d] && m_tready[d]) begin
            got = {m_tdata[d], m_tkeep[d], m_tlast[d], m_tuser[d]};
            total++;
            if (exp_q[d].size() == 0) begin
              bad++;
              $display("FAIL out%0d_unexpected: got=%h", d, got);
            end else begin
              want = exp_q[d].pop_front();
              if (got !== want) begin
                bad++;
                $display("FAIL out%0d_beat: got=%h want=%h", d, got, want);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge aclk);
    #1;
    aresetn[0] = 1'b1;
    aresetn[1] = 1'b1;
    @(negedge aclk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst%0d_tready", d), 64'(s_tready[d]), 64'd0);
      chk($sformatf("rst%0d_tvalid", d), 64'(m_tvalid[d]), 64'd0);
      chk($sformatf("rst%0d_tdata_nz", d), 64'(|m_tdata[d] | |m_tkeep[d]), 64'd0);
      chk($sformatf("rst%0d_busy", d), 64'(busy[d]), 64'd0);
      chk($sformatf("rst%0d_pkt_cnt_nz", d), 64'(|pkt_cnt[d]), 64'd0);
      chk($sformatf("rst%0d_trunc", d), 64'(trunc_cnt[d]), 64'd0);
    end

    // Single source, 9 beats, with first-beat latency
    @(posedge aclk);
    #1;
    exp_pkt(0, 0, 0, 9, 256);
    fork
      send_pkt(0, 0, 0, 9, 9, 1'b0, -1);
      begin
        @(negedge aclk);
        chk("lat_c0_tready", 64'(s_tready[0][0]), 64'd0);
        @(negedge aclk);
        chk("lat_c1_tready", 64'(s_tready[0][0]), 64'd1);
        chk("lat_c1_mvalid", 64'(m_tvalid[0]), 64'd0);
        @(negedge aclk);
        chk("lat_c2_mvalid", 64'(m_tvalid[0]), 64'd1);
      end
    join
    drain(0);
    chk("single_pkt_cnt0", 64'(pkt_cnt[0][31:0]), 64'd1);
    chk("single_pkt_cnt1", 64'(pkt_cnt[0][63:32]), 64'd0);
    chk("single_busy", 64'(busy[0]), 64'd0);

    // Round-robin from a fresh rr_ptr
    aresetn[0] = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn[0] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      exp_pkt(0, 0, p + 1, 4, 256);
      exp_pkt(0, 1, p + 1, 4, 256);
    end
    fork
      for (int p = 0; p < 3; p++) send_pkt(0, 0, p + 1, 4, 4, p < 2, -1);
      for (int p = 0; p < 3; p++) send_pkt(0, 1, p + 1, 4, 4, p < 2, -1);
    join
    drain(0);
    chk("rr_pkt_cnt0", 64'(pkt_cnt[0][31:0]), 64'd3);
    chk("rr_pkt_cnt1", 64'(pkt_cnt[0][63:32]), 64'd3);

    // Fixed priority: source 0 monopolises, source 1 waits
    exp_q[1].delete();
    for (int p = 0; p < 6; p++) exp_pkt(1, 0, p, 4, 4);
    exp_pkt(1, 1, 0, 4, 4);
    done = 1'b0;
    viol = 0;
    fork
      begin
        for (int p = 0; p < 6; p++) send_pkt(1, 0, p, 4, 4, p < 5, -1);
        done = 1'b1;
      end
      send_pkt(1, 1, 0, 4, 4, 1'b0, -1);
      while (!done) begin
        @(negedge aclk);
        if (s_tready[1][1]) viol++;
      end
    join
    chk("fp_src1_stalled", 64'(viol), 64'd0);
    drain(1);
    chk("fp_pkt_cnt0", 64'(pkt_cnt[1][31:0]), 64'd6);
    chk("fp_pkt_cnt1", 64'(pkt_cnt[1][63:32]), 64'd1);
    chk("fp_trunc_boundary", 64'(trunc_cnt[1]), 64'd0);

    // Truncation at MAX_BEATS=4, then a normal packet
    exp_pkt(1, 0, 10, 10, 4);
    send_pkt(1, 0, 10, 10, 10, 1'b0, -1);
    exp_pkt(1, 1, 11, 3, 4);
    send_pkt(1, 1, 11, 3, 3, 1'b0, -1);
    drain(1);
    chk("trunc_cnt", 64'(trunc_cnt[1]), 64'd1);
    chk("trunc_pkt_cnt0", 64'(pkt_cnt[1][31:0]), 64'd7);
    chk("trunc_pkt_cnt1", 64'(pkt_cnt[1][63:32]), 64'd2);
    chk("trunc_busy", 64'(busy[1]), 64'd0);

    // Random backpressure over 64 beats with a skid-occupancy model
    exp_pkt(0, 0, 20, 64, 256);
    done = 1'b0;
    fork
      begin
        send_pkt(0, 0, 20, 64, 64, 1'b0, -1);
        done = 1'b1;
      end
      begin
        int occ;
        occ = 0;
        while (!done) begin
          @(negedge aclk);
          total++;
          if (occ >= 2 && s_tready[0][0]) begin
            bad++;
            $display("FAIL bp_skid_full_ready: occ=%0d tready=1 want tready=0", occ);
          end
          occ = occ + int'(s_tvalid[0][0] && s_tready[0][0]) - int'(m_tvalid[0] && m_tready[0]);
          @(posedge aclk);
          #1;
          m_tready[0] = 1'($urandom_range(0, 1));
        end
      end
    join
    m_tready[0] = 1'b1;
    drain(0);
    chk("bp_pkt_cnt0", 64'(pkt_cnt[0][31:0]), 64'd4);

    // tx_enable dropped at beat 3 of 8; next packet waits for re-enable
    exp_pkt(0, 0, 30, 8, 256);
    exp_pkt(0, 0, 31, 5, 256);
    send_pkt(0, 0, 30, 8, 8, 1'b0, 2);
    viol = 0;
    fork
      send_pkt(0, 0, 31, 5, 5, 1'b0, -1);
      begin
        repeat (12) begin
          @(negedge aclk);
          if (s_tready[0][0] || busy[0]) viol++;
        end
        chk("txen_hold_off", 64'(viol), 64'd0);
        @(posedge aclk);
        #1;
        tx_enable[0] = 1'b1;
      end
    join
    drain(0);
    chk("txen_pkt_cnt0", 64'(pkt_cnt[0][31:0]), 64'd6);

    // Reset asserted after the 5th accepted beat of an 8-beat packet
    for (int b = 0; b < 4; b++) exp_q[0].push_back({mk_data(0, 40, b), mk_keep(40, b, 8), 1'b0, 1'b0});
    send_pkt(0, 0, 40, 8, 5, 1'b1, -1);
    aresetn[0] = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid[0]), 64'd0);
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_pkt_cnt_nz", 64'(|pkt_cnt[0]), 64'd0);
    chk("mid_rst_trunc", 64'(trunc_cnt[0]), 64'd0);
    chk("mid_rst_tready", 64'(s_tready[0]), 64'd0);
    chk("mid_rst_left", 64'(exp_q[0].size()), 64'd0);
    s_tvalid[0] = '0;
    s_tlast[0]  = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn[0] = 1'b1;
    repeat (3) @(negedge aclk);
    chk("post_rst_mvalid", 64'(m_tvalid[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
